// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } muldiv_state_t;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

endpackage

// File: rtl/muldiv_core.sv
// Radix-2 shift-add multiply / restoring divide datapath, one step per strobe.
// Divide path is present only when MULDIV_DIV_EN is defined.
module muldiv_core #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              step_i,
`ifdef MULDIV_DIV_EN
  input  logic              is_div_i,
`endif
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W:0]   sum_c;
`ifdef MULDIV_DIV_EN
  logic              div_q;
  logic [DATA_W:0]   shl_c;
  logic [DATA_W:0]   diff_c;
`endif

  // hi:lo is the product (multiply) or remainder:quotient (divide)
  always_comb begin
    hi_d  = hi_q;
    lo_d  = lo_q;
    sum_c = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
`ifdef MULDIV_DIV_EN
    shl_c  = {hi_q, lo_q[DATA_W-1]};
    diff_c = shl_c - {1'b0, b_q};
`endif
    if (load_i) begin
      hi_d = '0;
      lo_d = a_i;
    end else if (step_i) begin
`ifdef MULDIV_DIV_EN
      if (div_q) begin
        hi_d = diff_c[DATA_W] ? shl_c[DATA_W-1:0] : diff_c[DATA_W-1:0];
        lo_d = {lo_q[DATA_W-2:0], ~diff_c[DATA_W]};
      end else
`endif
      begin
        hi_d = sum_c[DATA_W:1];
        lo_d = {sum_c[0], lo_q[DATA_W-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      b_q   <= '0;
`ifdef MULDIV_DIV_EN
      div_q <= 1'b0;
`endif
    end else begin
      hi_q <= hi_d;
      lo_q <= lo_d;
      if (load_i) begin
        b_q   <= b_i;
`ifdef MULDIV_DIV_EN
        div_q <= is_div_i;
`endif
      end
    end
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// RV32M multiply/divide sequencer: FSM, special cases, sign fix-up, pipeline stall.
// Define MULDIV_DIV_EN to build the divide/remainder operations.
module muldiv_sequencer #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              flush,
  input  logic [2:0]        Funct3,
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  output logic              stall,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [DATA_W-1:0] Result
);
  import muldiv_pkg::*;

  localparam int unsigned     CNT_W     = $clog2(DATA_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

  muldiv_state_t       state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                sa_q, sa_d, sb_q, sb_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                busy_q, done_q, illegal_q, illegal_d;
  logic                load_c, step_c;
  logic                sa_c, sb_c;
  logic [DATA_W-1:0]   amag_c, bmag_c;
  logic [DATA_W-1:0]   hi_c, lo_c;
  logic [2*DATA_W-1:0] prod_raw_c, prod_c;
  logic [DATA_W-1:0]   fix_c;
`ifdef MULDIV_DIV_EN
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  logic                div_zero_c, ovf_c;
  logic [DATA_W-1:0]   special_c, quo_c, rem_c;
`endif

  // Operand sign flags and magnitudes for the signed flavours
  assign sa_c = SrcA[DATA_W-1] && (Funct3 == F3_MULH || Funct3 == F3_MULHSU ||
                                   Funct3 == F3_DIV  || Funct3 == F3_REM);
  assign sb_c = SrcB[DATA_W-1] && (Funct3 == F3_MULH || Funct3 == F3_DIV ||
                                   Funct3 == F3_REM);
  assign amag_c = sa_c ? -SrcA : SrcA;
  assign bmag_c = sb_c ? -SrcB : SrcB;

`ifdef MULDIV_DIV_EN
  assign div_zero_c = Funct3[2] && (SrcB == '0);
  assign ovf_c      = (Funct3 == F3_DIV || Funct3 == F3_REM) &&
                      (SrcA == MIN_NEG) && (SrcB == '1);
  assign special_c  = Funct3[1] ? (div_zero_c ? SrcA : '0)
                                : (div_zero_c ? '1   : SrcA);
  assign quo_c      = (sa_q ^ sb_q) ? -lo_c : lo_c;
  assign rem_c      = sa_q ? -hi_c : hi_c;
`endif

  assign prod_raw_c = {hi_c, lo_c};
  assign prod_c     = (sa_q ^ sb_q) ? -prod_raw_c : prod_raw_c;

  always_comb begin
    fix_c = prod_c[2*DATA_W-1:DATA_W];
    if (f3_q == F3_MUL) begin
      fix_c = prod_c[DATA_W-1:0];
    end
`ifdef MULDIV_DIV_EN
    else if (f3_q[2]) begin
      fix_c = f3_q[1] ? rem_c : quo_c;
    end
`endif
  end

  muldiv_core #(.DATA_W(DATA_W)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load_i   (load_c),
    .step_i   (step_c),
`ifdef MULDIV_DIV_EN
    .is_div_i (Funct3[2]),
`endif
    .a_i      (amag_c),
    .b_i      (bmag_c),
    .hi_o     (hi_c),
    .lo_o     (lo_c)
  );

  // Next-state and datapath control
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    result_d  = result_q;
    illegal_d = 1'b0;
    load_c    = 1'b0;
    step_c    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          f3_d  = Funct3;
          sa_d  = sa_c;
          sb_d  = sb_c;
          cnt_d = '0;
`ifdef MULDIV_DIV_EN
          if (div_zero_c || ovf_c) begin
            result_d = special_c;
            state_d  = S_DONE;
          end else begin
            load_c  = 1'b1;
            state_d = S_CALC;
          end
`else
          if (Funct3[2]) begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            load_c  = 1'b1;
            state_d = S_CALC;
          end
`endif
        end
      end
      S_CALC: begin
        step_c = 1'b1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        result_d = fix_c;
        state_d  = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Abort leaves Result untouched and suppresses the done pulse
    if (flush) begin
      state_d   = S_IDLE;
      result_d  = result_q;
      illegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      sa_q      <= 1'b0;
      sb_q      <= 1'b0;
      result_q  <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      sa_q      <= sa_d;
      sb_q      <= sb_d;
      result_q  <= result_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      illegal_q <= illegal_d;
    end
  end

  // Combinational so the instruction is held in EX from its first cycle
  assign stall   = ((state_q == S_IDLE) && start && !flush) ||
                   (state_q == S_CALC) || (state_q == S_FIX);
  assign busy    = busy_q;
  assign done    = done_q;
  assign illegal = illegal_q;
  assign Result  = result_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer; expectations follow MULDIV_DIV_EN.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  Funct3 = 3'd0;
  logic [31:0] SrcA = '0;
  logic [31:0] SrcB = '0;
  logic        stall, busy, done, illegal;
  logic [31:0] Result;

  int n_tests = 0;
  int n_fail  = 0;
  logic chk_en = 1'b0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.DATA_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .flush   (flush),
    .Funct3  (Funct3),
    .SrcA    (SrcA),
    .SrcB    (SrcB),
    .stall   (stall),
    .busy    (busy),
    .done    (done),
    .illegal (illegal),
    .Result  (Result)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic: returns {illegal, result}
  function automatic logic [32:0] model_fn(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] b);
    logic signed [63:0] sa, sb, p;
    logic [63:0] ua, ub, pu;
    logic [31:0] r;
    logic ovf;
    int ia, ib;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    ia = a;
    ib = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0;
    case (f3)
      3'd0: r = a * b;
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * $signed(ub); r = p[63:32]; end
      3'd3: begin pu = ua * ub; r = pu[63:32]; end
`ifdef MULDIV_DIV_EN
      3'd4: r = (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(ia / ib);
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: r = (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
      3'd7: r = (b == 0) ? a : a % b;
`else
      default: return {1'b1, 32'd0};
`endif
    endcase
    return {1'b0, r};
  endfunction

  function automatic int lat_fn(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return 34;
`ifdef MULDIV_DIV_EN
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 34;
`else
    return 1;
`endif
  endfunction

  // Cycle model: m_left = cycles until idle again; done on the last one
  int          m_left = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pend = '0;
  logic        m_pill = 1'b0;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_left = 0;
      m_res  = '0;
      m_pill = 1'b0;
    end else if (flush) begin
      m_left = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 1) m_res = m_pend;
    end else if (start) begin
      {m_pill, m_pend} = model_fn(Funct3, SrcA, SrcB);
      m_left = lat_fn(Funct3, SrcA, SrcB);
      if (m_left == 1) m_res = m_pend;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_stall",   {31'd0, stall},   {31'd0, (m_left == 0 && start && !flush) || m_left > 1});
      chk("cyc_busy",    {31'd0, busy},    {31'd0, m_left > 0});
      chk("cyc_done",    {31'd0, done},    {31'd0, m_left == 1});
      chk("cyc_illegal", {31'd0, illegal}, {31'd0, m_left == 1 && m_pill});
      chk("cyc_result",  Result, m_res);
    end
  end

  task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_r, input logic exp_ill,
                        input int exp_lat);
    int got = -1;
    int stall_n = 0;
    @(posedge clk); #1;
    Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
    for (int c = 0; c <= 100; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        start = 1'b0;
      end
      #1;
      if (done) begin
        got = c;
        break;
      end
      if (stall) stall_n++;
    end
    chk({nm, "_latency"}, 32'(got), 32'(exp_lat));
    chk({nm, "_result"}, Result, exp_r);
    chk({nm, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
    chk({nm, "_stall_cycles"}, 32'(stall_n), 32'(exp_lat));
    chk({nm, "_stall_at_done"}, {31'd0, stall}, 32'd0);
  endtask

  // Divide-family vectors; disabled builds must flag them illegal
  task automatic run_div(input string nm, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_r, input int exp_lat);
`ifdef MULDIV_DIV_EN
    run_op(nm, f3, a, b, exp_r, 1'b0, exp_lat);
`else
    run_op(nm, f3, a, b, 32'd0, 1'b1, 1 + 0 * exp_lat + 0 * int'(exp_r[0]));
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int d1, d2;
    logic [31:0] r1, r2, prev;
    #2 reset = 1'b0;
    #1 chk_en = 1'b1;
    @(negedge clk);
    chk("rst_result", Result, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_illegal", {31'd0, illegal}, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 34);
    run_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 34);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 34);

    // Reset asserted mid-CALC clears everything immediately
    @(posedge clk); #1;
    Funct3 = 3'd0; SrcA = 32'd9; SrcB = 32'd9; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("rstmid_stall", {31'd0, stall}, 32'd0);
    chk("rstmid_busy", {31'd0, busy}, 32'd0);
    chk("rstmid_done", {31'd0, done}, 32'd0);
    chk("rstmid_illegal", {31'd0, illegal}, 32'd0);
    chk("rstmid_result", Result, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;

    run_op("mulhsu_-1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 1'b0, 34);
    run_op("mul_lo_wrap", 3'd0, 32'h0001_0000, 32'h0001_0000, 32'd0, 1'b0, 34);
    run_op("mulhu_carry", 3'd3, 32'h0001_0000, 32'h0001_0000, 32'd1, 1'b0, 34);
    run_div("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34);
    run_div("rem_-7%2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34);
    run_div("divu_100/7", 3'd5, 32'd100, 32'd7, 32'd14, 34);
    run_div("remu_100%7", 3'd7, 32'd100, 32'd7, 32'd2, 34);
    run_div("div_by0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_div("remu_by0", 3'd7, 32'd5, 32'd0, 32'd5, 1);
    run_div("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_div("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("mulh_neg", 3'd1, 32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 1'b0, 34);

    // Flush in cycle 10: idle in cycle 11, Result kept, no done
    prev = Result;
    @(posedge clk); #1;
`ifdef MULDIV_DIV_EN
    Funct3 = 3'd4;
`else
    Funct3 = 3'd3;
`endif
    SrcA = 32'd100; SrcB = 32'd7; start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    #1;
    chk("flush_busy", {31'd0, busy}, 32'd0);
    chk("flush_result", Result, prev);
    d1 = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #2;
      if (done) d1++;
    end
    chk("flush_no_done", 32'(d1), 32'd0);

    // start together with flush in IDLE is rejected
    @(posedge clk); #1;
    start = 1'b1; flush = 1'b1; Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd3;
    #1 chk("startflush_stall", {31'd0, stall}, 32'd0);
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    #1 chk("startflush_busy", {31'd0, busy}, 32'd0);

    // start held high: second op accepted the cycle after DONE
    d1 = -1; d2 = -1; r1 = '0; r2 = '0;
    @(posedge clk); #1;
    Funct3 = 3'd0; SrcA = 32'd3; SrcB = 32'd5; start = 1'b1;
    for (int c = 1; c <= 120; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin SrcA = 32'd6; SrcB = 32'd7; end
      #1;
      if (done) begin
        if (d1 < 0) begin d1 = c; r1 = Result; end
        else begin d2 = c; r2 = Result; break; end
      end
    end
    start = 1'b0;
    chk("b2b_first_done", 32'(d1), 32'd34);
    chk("b2b_first_result", r1, 32'd15);
    chk("b2b_second_done", 32'(d2), 32'd69);
    chk("b2b_second_result", r2, 32'd42);

    repeat (3) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

- Sequences an iterative radix-2 multiply/divide datapath for the RV32M instructions (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
- Sits beside the EX-stage ALU: the EX stage raises `start` for OP-type instructions with Funct7 = 0000001.
- The block holds the pipeline with `stall` until the result is ready, and supports abort on flush.

## Interface
Parameters:
- `DATA_W`, default 32: operand and result width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a new operation; sampled only in IDLE.
- `flush`  in  1  synchronous abort of the current operation.
- `Funct3`  in  3  operation select (instruction bits 14:12).
- `SrcA`  in  DATA_W  rs1 operand (multiplicand or dividend).
- `SrcB`  in  DATA_W  rs2 operand (multiplier or divisor).
- `stall`  out  1  freeze the IF/ID/EX pipeline registers.
- `busy`  out  1  FSM is not in IDLE.
- `done`  out  1  one-cycle pulse; `Result` is valid.
- `illegal`  out  1  one-cycle pulse with `done` for an unsupported operation.
- `Result`  out  DATA_W  final value; held until the next accepted `start`.

## Operation
FSM states: IDLE, CALC, FIX, DONE.
- **IDLE**
  - `start`=1 and `flush`=0: capture `SrcA`, `SrcB` and `Funct3`, and store operand magnitudes and sign flags.
  - Signed ops: DIV, REM, MULH (both operands signed); MULHSU (`SrcA` only).
  - Special cases go IDLE→DONE directly:
    - divisor = 0: quotient all-ones, remainder = dividend.
    - signed overflow (dividend = 100..0, divisor = all-ones): quotient = dividend, remainder = 0.
  - All other cases go to CALC, counter = 0.
- **CALC**
  - One shift-add (multiply) or restoring shift-subtract (divide) step per cycle.
  - Moves to FIX after exactly `DATA_W` steps; counter width is clog2(`DATA_W`)+1.
- **FIX**
  - Applies sign correction: product negated if the sign flags differ; quotient negated if the operand signs differ; remainder takes the dividend's sign.
  - Selects the result:
    - low product half: MUL.
    - high product half: MULH, MULHSU, MULHU.
    - quotient: DIV, DIVU.
    - remainder: REM, REMU.
  - Registers `Result`, then goes to DONE.
- **DONE**
  - `done`=1 for one cycle, then unconditionally to IDLE.
  - `start` is ignored in this cycle.
- **Product arithmetic:** full 2·`DATA_W`-bit product on magnitudes; all arithmetic is modulo 2^`DATA_W` per half.
- **`flush`:** in any state, the next state is IDLE with no `done` pulse. `Result` keeps its old value. `flush` wins over a simultaneous `start`.
- **`start` outside IDLE:** ignored, with no queuing.

## Timing
- **Reset values:** state IDLE; `stall`, `busy`, `done` and `illegal` = 0; `Result` = 0; counter = 0. Asserting `reset` mid-operation aborts immediately, with no `done`.
- **`stall`** = (IDLE & `start` & !`flush`) | CALC | FIX. It is combinational from `start`, so the instruction is frozen in EX from its first cycle. It is 0 in DONE, so the pipeline advances in the same cycle `Result` is consumed.
- **Latency** (cycle 0 = cycle in which `start` is sampled in IDLE):
  - normal ops: CALC in cycles 1..`DATA_W`, FIX in `DATA_W`+1, `done` in `DATA_W`+2 (cycle 34 for 32-bit).
  - special cases: `done` in cycle 1.
- **Back-to-back:** the earliest next accept is the cycle after DONE. Throughput is one op per `DATA_W`+3 cycles.
- **`busy`:** high from cycle 1 through the DONE cycle inclusive.

## Configuration
- **`MULDIV_DIV_EN` defined:** all eight operations are supported as above.
- **`MULDIV_DIV_EN` undefined:**
  - Divider logic and the divide special-case checks are removed.
  - Funct3[2]=1 in IDLE goes IDLE→DONE with `Result` = 0 and `illegal`=1 alongside `done`.
  - Multiply ops are unchanged.

## Structure
- **Package `muldiv_pkg`:** FSM state enum `muldiv_state_t`, and Funct3 constants `F3_MUL` … `F3_REMU` (000…111).
- **Sub-module `muldiv_core`:** the shift/add/subtract datapath registers, one step per `step` strobe.
  - `muldiv_sequencer` owns the FSM, counter, special-case detection, sign fix-up and handshake.

## Test plan
- **MUL:** MUL 7 × −3 (0xFFFFFFFD) → `Result` 0xFFFFFFEB, `done` exactly in cycle 34, `stall` high for cycles 0–33 and low in cycle 34.
- **Multiply high:**
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0x2 → 0xFFFFFFFF.
- **Signed divide/remainder:** DIV −7 / 2 → 0xFFFFFFFD; REM −7 % 2 → 0xFFFFFFFF; DIVU 100 / 7 → 14; REMU 100 % 7 → 2.
- **Special cases:**
  - DIV 5 / 0 → 0xFFFFFFFF in cycle 1; REMU 5 % 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same operands → 0.
- **Flush and reset:**
  - `flush` in cycle 10 of a DIV → IDLE in cycle 11, no `done`, `Result` unchanged.
  - `start`+`flush` together in IDLE → not accepted.
  - `reset` low mid-CALC → all outputs 0 immediately.
- **Back-to-back and config:**
  - `start` held high → second op accepted in cycle 35; `start` during DONE is ignored.
  - Build without `MULDIV_DIV_EN`: DIV → `done`+`illegal` in cycle 1, `Result` 0.
